// File: rtl/cpu_defs.sv
`default_nettype none
// ============================================================================
//  Package     : cpu_defs
//  Description : Opcodes, constants and helpers shared by the fetch stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_defs;

    localparam logic [5:0]  OP_J             = 6'b000010;
    localparam logic [5:0]  OP_BEQ           = 6'b000100;
    localparam logic [5:0]  OP_BNE           = 6'b000101;
    localparam logic [31:0] NOP_WORD         = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] WORD_ALIGN_MASK  = 32'hFFFF_FFFC;

    // Source chosen for the next program counter.
    typedef enum logic [1:0] {
        SRC_SEQ      = 2'd0,
        SRC_JUMP     = 2'd1,
        SRC_HOLD     = 2'd2,
        SRC_REDIRECT = 2'd3
    } pc_src_e;

    // True when the word is an unconditional j instruction.
    function automatic logic is_jump(input logic [31:0] inst);
        return (inst[31:26] == OP_J);
    endfunction

endpackage : cpu_defs
`default_nettype wire

// File: rtl/next_pc_sel.sv
`default_nettype none
// ============================================================================
//  Module      : next_pc_sel
//  Description : Combinational next-PC priority mux (redirect > stall > jump >
//                sequential) plus the IF/ID load and bubble enables.
//  Revision    : 1.0 - initial release
// ============================================================================
module next_pc_sel
    import cpu_defs::*;
(
    input  logic [31:0] i_pc,
    input  logic [31:0] i_inst,
    input  logic        i_stall,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic [31:0] o_next_pc,
    output logic [31:0] o_pc_plus4,
    output logic        o_load,
    output logic        o_bubble
);

    pc_src_e     w_src;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_jump_target;

    // Select the PC source by priority and form the candidate addresses.
    always_comb begin
        w_src         = SRC_SEQ;
        w_pc_plus4    = i_pc + 32'd4;
        w_jump_target = {w_pc_plus4[31:28], i_inst[25:0], 2'b00};
        o_next_pc     = w_pc_plus4;
        o_load        = 1'b0;
        o_bubble      = 1'b0;

        if (i_redirect) begin
            w_src = SRC_REDIRECT;
        end else if (i_stall) begin
            w_src = SRC_HOLD;
        end else if (is_jump(i_inst)) begin
            w_src = SRC_JUMP;
        end

        case (w_src)
            SRC_REDIRECT: begin
                o_next_pc = i_redirect_pc & WORD_ALIGN_MASK;
                o_bubble  = 1'b1;
            end
            SRC_HOLD: begin
                o_next_pc = i_pc;
            end
            SRC_JUMP: begin
                // The j word itself still enters IF/ID as a valid entry.
                o_next_pc = w_jump_target;
                o_load    = 1'b1;
            end
            default: begin
                o_next_pc = w_pc_plus4;
                o_load    = 1'b1;
            end
        endcase
    end

    assign o_pc_plus4 = w_pc_plus4;

endmodule : next_pc_sel
`default_nettype wire

// File: rtl/inst_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : inst_fetch
//  Description : Instruction fetch stage: PC register, IF/ID pipeline register
//                and fetch counter, with stall, redirect and local j handling.
//  Revision    : 1.0 - initial release
// ============================================================================
module inst_fetch
    import cpu_defs::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        Clk,
    input  logic        Reset,
    output logic [31:0] Addr,
    input  logic [31:0] Inst,
    input  logic        Stall,
    input  logic        Redirect,
    input  logic [31:0] RedirectPc,
    output logic [31:0] IfId_Inst,
    output logic [31:0] IfId_PcPlus4,
    output logic        IfId_Valid,
    output logic [31:0] FetchCount
);

    logic [31:0] r_pc;
    logic [31:0] r_ifid_inst;
    logic [31:0] r_ifid_pc_plus4;
    logic        r_ifid_valid;
    logic [31:0] r_fetch_count;

    logic [31:0] w_next_pc;
    logic [31:0] w_pc_plus4;
    logic        w_load;
    logic        w_bubble;

    next_pc_sel u_next_pc_sel (
        .i_pc          (r_pc),
        .i_inst        (Inst),
        .i_stall       (Stall),
        .i_redirect    (Redirect),
        .i_redirect_pc (RedirectPc),
        .o_next_pc     (w_next_pc),
        .o_pc_plus4    (w_pc_plus4),
        .o_load        (w_load),
        .o_bubble      (w_bubble)
    );

    // PC, IF/ID register and fetch counter; reset overrides everything.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_pc            <= RESET_PC;
            r_ifid_inst     <= NOP_WORD;
            r_ifid_pc_plus4 <= 32'h0000_0000;
            r_ifid_valid    <= 1'b0;
            r_fetch_count   <= 32'h0000_0000;
        end else begin
            r_pc <= w_next_pc;
            if (w_bubble) begin
                // PC+4 field is left as-is on a bubble.
                r_ifid_inst  <= NOP_WORD;
                r_ifid_valid <= 1'b0;
            end else if (w_load) begin
                r_ifid_inst     <= Inst;
                r_ifid_pc_plus4 <= w_pc_plus4;
                r_ifid_valid    <= 1'b1;
                r_fetch_count   <= r_fetch_count + 32'd1;
            end
        end
    end

    assign Addr         = r_pc;
    assign IfId_Inst    = r_ifid_inst;
    assign IfId_PcPlus4 = r_ifid_pc_plus4;
    assign IfId_Valid   = r_ifid_valid;
    assign FetchCount   = r_fetch_count;

endmodule : inst_fetch
`default_nettype wire

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch stage that drives the instruction memory. It holds the program counter and presents it as the word address to the instruction memory, which answers combinationally in the same cycle. It captures the returned word into the IF/ID pipeline register. It handles stall, flush and redirect requests from later stages, and it resolves unconditional `j` instructions locally with no bubble.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset; must be word-aligned.
- `Clk` input 1: single clock; all state updates on the rising edge.
- `Reset` input 1: synchronous, active-high.
- `Addr` output 32: current PC, driven to the instruction memory address port. The memory indexes with `Addr[6:2]`, giving 32 words.
- `Inst` input 32: instruction word returned by the instruction memory for `Addr`, valid in the same cycle.
- `Stall` input 1: hold the PC and the IF/ID register.
- `Redirect` input 1: taken branch resolved downstream; `RedirectPc` is the new PC.
- `RedirectPc` input 32: branch target; bits [1:0] are ignored (forced to 0).
- `IfId_Inst` output 32: registered instruction.
- `IfId_PcPlus4` output 32: registered fetch PC + 4.
- `IfId_Valid` output 1: IF/ID holds a real instruction (0 = bubble).
- `FetchCount` output 32: number of instructions accepted into IF/ID.

## Operation
- Combinational next-PC selection. Priority runs from highest to lowest:
  - Reset.
  - Redirect: PC ← `{RedirectPc[31:2],2'b00}`.
  - Stall: PC holds.
  - Jump: `Inst[31:26]==6'b000010` gives PC ← `{PC+4[31:28], Inst[25:0], 2'b00}`.
  - Otherwise: PC ← PC+4.
- PC+4 is a 32-bit add that wraps at 2^32. Bits above [6:2] are kept in the PC and are not truncated.
- IF/ID update, using the same priority:
  - Redirect: IF/ID ← bubble (`IfId_Inst`=32'h0000_0000 NOP, `IfId_Valid`=0, `IfId_PcPlus4` unchanged).
  - Stall (no redirect): IF/ID holds all fields.
  - Otherwise: `IfId_Inst`←`Inst`, `IfId_PcPlus4`←PC+4, `IfId_Valid`←1.
- A `j` instruction is still passed into IF/ID as valid. Downstream treats it as no-writeback.
- `FetchCount` increments by 1 on each cycle in which IF/ID loads a valid instruction. It wraps modulo 2^32.
- Redirect together with Stall: redirect wins. The PC is loaded and IF/ID is bubbled.
- Redirect together with a `j` in the current `Inst`: redirect wins, and the `j` is squashed (not loaded, not counted).
- Stall together with a `j`: the PC holds and the jump is re-evaluated next cycle from the same `Inst`.
- Reset asserted mid-operation overrides everything on the next edge. Pending redirect or jump state is discarded.

## Timing
- Reset values:
  - `Addr`=`RESET_PC`
  - `IfId_Inst`=0
  - `IfId_PcPlus4`=0
  - `IfId_Valid`=0
  - `FetchCount`=0
- `Addr` is a register output, with no combinational path from inputs to `Addr`.
- Fetch latency is 1 cycle: the word at `Addr` in cycle n appears on `IfId_Inst` in cycle n+1.
- Redirect cost:
  - Asserted in cycle n: `Addr`=target in n+1 and IF/ID holds a bubble in n+1.
  - The target instruction is in IF/ID in n+2.
- Jump cost is zero bubbles: `j` fetched in cycle n gives `Addr`=target in n+1.
- `Stall` is level-sensitive. Every cycle it is high, with no redirect, freezes PC, IF/ID and `FetchCount`.

## Structure
- Shared package `cpu_defs` holds:
  - `OP_J`=6'b000010, `OP_BEQ`=6'b000100, `OP_BNE`=6'b000101.
  - `NOP_WORD`=32'h0000_0000.
  - `DEFAULT_RESET_PC`.
  - `WORD_ALIGN_MASK`.
- One sub-module, `next_pc_sel`: purely combinational priority mux (redirect / stall / jump / sequential) producing the next PC and the IF/ID load/bubble enables.
- The PC register, IF/ID register and counter live in `inst_fetch`.

## Test plan
- Reset with `RESET_PC`=0 and memory preloaded with sequential non-jump words:
  - After reset, `Addr`=0x00, 0x04, 0x08 on consecutive cycles.
  - `IfId_Valid` is 0 in the first cycle, then 1.
  - `IfId_PcPlus4`=0x04 holding word 0.
- `j` at word 0x10 (`Inst`=32'h0800000E):
  - `Addr` goes 0x40 → 0x38 with no bubble.
  - IF/ID holds the `j` with `IfId_PcPlus4`=0x44.
  - The next IF/ID entry is word 0x0E.
- `Redirect`=1, `RedirectPc`=0x2B at `Addr`=0x10:
  - Next `Addr`=0x28 and IF/ID is a bubble (`IfId_Valid`=0).
  - `FetchCount` does not increment that cycle.
- `Stall` high for 3 cycles at `Addr`=0x0C:
  - `Addr`, IF/ID and `FetchCount` are frozen for 3 cycles.
  - Sequencing resumes with 0x10.
- `Stall` and `Redirect` together, with a `j` present on `Inst`:
  - `Addr`=`RedirectPc`.
  - IF/ID is a bubble and the jump is ignored.
- `Reset` asserted while `Redirect`=1: all outputs return to their reset values on the next edge.
